// File: rtl/sram2rw_pkg.sv
// Shared types and byte helpers for the sram2rw dual-port RAM controller.
// SRAM2RW_PARITY_EN enables per-byte parity storage and checking in the users of this package.
package sram2rw_pkg;

    localparam int unsigned MaxDataW = 256;
    localparam int unsigned MaxBytes = MaxDataW / 8;

    typedef enum logic [0:0] {ST_CLEAR, ST_IDLE} state_e;

    // Bytes with be set come from new_word, the rest keep old_word.
    function automatic logic [MaxDataW-1:0] byte_merge(
        input logic [MaxDataW-1:0] old_word,
        input logic [MaxDataW-1:0] new_word,
        input logic [MaxBytes-1:0] be
    );
        logic [MaxDataW-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MaxBytes; k++) begin
            if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
        end
        return merged;
    endfunction

    // Even parity: each bit makes its byte plus parity bit have an even number of ones.
    function automatic logic [MaxBytes-1:0] byte_parity(input logic [MaxDataW-1:0] word);
        logic [MaxBytes-1:0] par;
        for (int k = 0; k < MaxBytes; k++) begin
            par[k] = ^word[8*k +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/sram2rw_port_pipe.sv
// Per-port read output stage: one register stage, plus a second one when OUT_REG is set.
// SRAM2RW_PARITY_EN adds a parity-error flag travelling alongside the read data.
module sram2rw_port_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OUT_REG = 0
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] rd_data_i,
`ifdef SRAM2RW_PARITY_EN
    input  logic              perr_i,
    output logic              perr_o,
`endif
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);

    logic [DATA_W-1:0] s1_data_q;
    logic              s1_valid_q;

    // Data only loads on a read so rdata holds between pulses.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_en_i;
            if (rd_en_i) s1_data_q <= rd_data_i;
        end
    end

`ifdef SRAM2RW_PARITY_EN
    logic s1_perr_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) s1_perr_q <= 1'b0;
        else         s1_perr_q <= rd_en_i & perr_i;
    end
`endif

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] s2_data_q;
        logic              s2_valid_q;

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_data_q <= s1_data_q;
            end
        end

        assign rdata_o  = s2_data_q;
        assign rvalid_o = s2_valid_q;

`ifdef SRAM2RW_PARITY_EN
        logic s2_perr_q;

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) s2_perr_q <= 1'b0;
            else         s2_perr_q <= s1_perr_q;
        end

        assign perr_o = s2_perr_q;
`endif
    end else begin : g_no_out_reg
        assign rdata_o  = s1_data_q;
        assign rvalid_o = s1_valid_q;
`ifdef SRAM2RW_PARITY_EN
        assign perr_o   = s1_perr_q;
`endif
    end

endmodule

// File: rtl/sram2rw_ctrl.sv
// True dual-port synchronous RAM with byte enables, post-reset clear and write/write arbitration.
// SRAM2RW_PARITY_EN adds one stored even-parity bit per byte and a_perr_o/b_perr_o outputs.
module sram2rw_ctrl
    import sram2rw_pkg::*;
#(
    parameter int unsigned  DATA_W       = 32,
    parameter int unsigned  DEPTH        = 128,
    parameter int unsigned  OUT_REG      = 0,
    parameter int unsigned  CLEAR_ON_RST = 1,
    localparam int unsigned ADDR_W       = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                a_req_i,
    input  logic                a_we_i,
    input  logic [DATA_W/8-1:0] a_be_i,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic [DATA_W-1:0]   a_wdata_i,
    output logic [DATA_W-1:0]   a_rdata_o,
    output logic                a_rvalid_o,
    input  logic                b_req_i,
    input  logic                b_we_i,
    input  logic [DATA_W/8-1:0] b_be_i,
    input  logic [ADDR_W-1:0]   b_addr_i,
    input  logic [DATA_W-1:0]   b_wdata_i,
    output logic [DATA_W-1:0]   b_rdata_o,
    output logic                b_rvalid_o,
`ifdef SRAM2RW_PARITY_EN
    output logic                a_perr_o,
    output logic                b_perr_o,
`endif
    output logic                ready_o,
    output logic                collision_o
);

    localparam int unsigned NB = DATA_W / 8;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ready_q;
    logic              collision_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_rd, a_wr, b_rd, b_wr, coll;
    logic [DATA_W-1:0] a_old, b_old, a_new, b_base, b_new;
    logic [NB-1:0]     b_be_eff;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt_q   <= '0;
            ready_q     <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ready_q     <= (state_d == ST_IDLE);
            collision_q <= coll;
        end
    end

    assign ready_o     = ready_q;
    assign collision_o = collision_q;

    // A write with no byte enabled is a no-op and never counts toward a collision.
    assign a_rd = a_req_i & ready_q & ~a_we_i;
    assign b_rd = b_req_i & ready_q & ~b_we_i;
    assign a_wr = a_req_i & ready_q & a_we_i & (|a_be_i);
    assign b_wr = b_req_i & ready_q & b_we_i & (|b_be_i);
    assign coll = a_wr & b_wr & (a_addr_i == b_addr_i);

    assign a_old = mem[a_addr_i];
    assign b_old = mem[b_addr_i];

    // On a collision B's write is issued last and carries A's bytes too, so A wins overlaps.
    assign b_be_eff = coll ? (b_be_i & ~a_be_i) : b_be_i;
    assign a_new    = DATA_W'(byte_merge(MaxDataW'(a_old), MaxDataW'(a_wdata_i),
                                         MaxBytes'(a_be_i)));
    assign b_base   = coll ? a_new : b_old;
    assign b_new    = DATA_W'(byte_merge(MaxDataW'(b_base), MaxDataW'(b_wdata_i),
                                         MaxBytes'(b_be_eff)));

    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            if (a_wr) mem[a_addr_i] <= a_new;
            if (b_wr) mem[b_addr_i] <= b_new;
        end
    end

`ifdef SRAM2RW_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic          a_perr, b_perr;

    assign a_perr = |(NB'(byte_parity(MaxDataW'(a_old))) ^ par_mem[a_addr_i]);
    assign b_perr = |(NB'(byte_parity(MaxDataW'(b_old))) ^ par_mem[b_addr_i]);

    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            par_mem[clr_cnt_q] <= '0;
        end else begin
            if (a_wr) par_mem[a_addr_i] <= NB'(byte_parity(MaxDataW'(a_new)));
            if (b_wr) par_mem[b_addr_i] <= NB'(byte_parity(MaxDataW'(b_new)));
        end
    end
`endif

    sram2rw_port_pipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_pipe_a (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .rd_en_i   (a_rd),
        .rd_data_i (a_old),
`ifdef SRAM2RW_PARITY_EN
        .perr_i    (a_perr),
        .perr_o    (a_perr_o),
`endif
        .rdata_o   (a_rdata_o),
        .rvalid_o  (a_rvalid_o)
    );

    sram2rw_port_pipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_pipe_b (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .rd_en_i   (b_rd),
        .rd_data_i (b_old),
`ifdef SRAM2RW_PARITY_EN
        .perr_i    (b_perr),
        .perr_o    (b_perr_o),
`endif
        .rdata_o   (b_rdata_o),
        .rvalid_o  (b_rvalid_o)
    );

endmodule

// File: tb/tb_sram2rw_ctrl.sv
// Bench for sram2rw_ctrl: directed and random traffic against a word-array reference model.
// Define SRAM2RW_PARITY_EN to also exercise the parity error outputs.
module tb_sram2rw_ctrl;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned DEPTH        = 128;
    localparam int unsigned OUT_REG      = 0;
    localparam int unsigned CLEAR_ON_RST = 1;
    localparam int unsigned AW           = $clog2(DEPTH);
    localparam int unsigned NB           = DATA_W / 8;
    localparam int unsigned LAT          = (OUT_REG != 0) ? 2 : 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [NB-1:0]     a_be = '0, b_be = '0;
    logic [AW-1:0]     a_addr = '0, b_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              a_rvalid, b_rvalid, ready, collision;
`ifdef SRAM2RW_PARITY_EN
    logic              a_perr, b_perr;
`endif

    always #5 clk = ~clk;

    sram2rw_ctrl #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .OUT_REG      (OUT_REG),
        .CLEAR_ON_RST (CLEAR_ON_RST)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .a_req_i     (a_req),
        .a_we_i      (a_we),
        .a_be_i      (a_be),
        .a_addr_i    (a_addr),
        .a_wdata_i   (a_wdata),
        .a_rdata_o   (a_rdata),
        .a_rvalid_o  (a_rvalid),
        .b_req_i     (b_req),
        .b_we_i      (b_we),
        .b_be_i      (b_be),
        .b_addr_i    (b_addr),
        .b_wdata_i   (b_wdata),
        .b_rdata_o   (b_rdata),
        .b_rvalid_o  (b_rvalid),
`ifdef SRAM2RW_PARITY_EN
        .a_perr_o    (a_perr),
        .b_perr_o    (b_perr),
`endif
        .ready_o     (ready),
        .collision_o (collision)
    );

    // Reference model: the RAM as a plain word array plus queues of reads still in flight.
    typedef struct {
        int unsigned       due;
        logic [DATA_W-1:0] data;
        logic              perr;
    } pend_t;

    logic [DATA_W-1:0] mem_m [DEPTH];
    logic              bad_m [DEPTH];
    pend_t             qa[$], qb[$];
    logic [DATA_W-1:0] last_a = '0, last_b = '0;
    logic              ready_m = 1'b0, coll_m = 1'b0;
    int unsigned       since_rel = 0;
    int unsigned       cyc = 0;
    int                n_checks = 0;
    int                n_fail = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic req, input logic we, input logic [NB-1:0] be,
                         input logic [AW-1:0] addr, input logic [DATA_W-1:0] wd);
        a_req = req; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [NB-1:0] be,
                         input logic [AW-1:0] addr, input logic [DATA_W-1:0] wd);
        b_req = req; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
    endtask

    task automatic rand_inputs(input int unsigned max_addr);
        set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NB'($urandom),
              AW'($urandom_range(0, max_addr)), $urandom);
        set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NB'($urandom),
              AW'($urandom_range(0, max_addr)), $urandom);
    endtask

    // Apply the current inputs for one clock, advance the model, then compare all outputs.
    task automatic cycle();
        logic  ok_a, ok_b, wa, wb, exp_v, exp_pe;
        pend_t p;
        ok_a   = a_req && ready_m;
        ok_b   = b_req && ready_m;
        wa     = ok_a && a_we && (a_be != '0);
        wb     = ok_b && b_we && (b_be != '0);
        coll_m = wa && wb && (a_addr == b_addr);
        if (ok_a && !a_we) begin
            p.due = cyc + LAT; p.data = mem_m[a_addr]; p.perr = bad_m[a_addr];
            qa.push_back(p);
        end
        if (ok_b && !b_we) begin
            p.due = cyc + LAT; p.data = mem_m[b_addr]; p.perr = bad_m[b_addr];
            qb.push_back(p);
        end
        // B is applied first so A's bytes win where both write the same word
        if (wb) bad_m[b_addr] = 1'b0;
        if (wa) bad_m[a_addr] = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (wb && b_be[k]) mem_m[b_addr][8*k +: 8] = b_wdata[8*k +: 8];
        end
        for (int k = 0; k < NB; k++) begin
            if (wa && a_be[k]) mem_m[a_addr][8*k +: 8] = a_wdata[8*k +: 8];
        end
        if (!ready_m) begin
            since_rel++;
            if (since_rel == DEPTH) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem_m[i] = '0;
                    bad_m[i] = 1'b0;
                end
                ready_m = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_bit("ready", ready, ready_m);
        check_bit("collision", collision, coll_m);

        exp_v  = (qa.size() > 0) && (qa[0].due == cyc);
        exp_pe = 1'b0;
        if (exp_v) begin
            p = qa.pop_front(); last_a = p.data; exp_pe = p.perr;
        end
        check_bit("a_rvalid", a_rvalid, exp_v);
        check("a_rdata", a_rdata, last_a);
`ifdef SRAM2RW_PARITY_EN
        check_bit("a_perr", a_perr, exp_pe);
`endif

        exp_v  = (qb.size() > 0) && (qb[0].due == cyc);
        exp_pe = 1'b0;
        if (exp_v) begin
            p = qb.pop_front(); last_b = p.data; exp_pe = p.perr;
        end
        check_bit("b_rvalid", b_rvalid, exp_v);
        check("b_rdata", b_rdata, last_b);
`ifdef SRAM2RW_PARITY_EN
        check_bit("b_perr", b_perr, exp_pe);
`endif
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
        cycle();
    endtask

    task automatic reset_pulse(input int unsigned n);
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
        rstn = 1'b0;
        qa.delete();
        qb.delete();
        last_a    = '0;
        last_b    = '0;
        ready_m   = 1'b0;
        coll_m    = 1'b0;
        since_rel = 0;
        #1;
        check_bit("rst_async_ready", ready, 1'b0);
        check_bit("rst_async_a_rvalid", a_rvalid, 1'b0);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            check_bit("rst_ready", ready, 1'b0);
            check_bit("rst_collision", collision, 1'b0);
            check_bit("rst_b_rvalid", b_rvalid, 1'b0);
            check("rst_a_rdata", a_rdata, '0);
            check("rst_b_rdata", b_rdata, '0);
        end
        rstn = 1'b1;
    endtask

    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            bad_m[i] = 1'b0;
        end
        #2;
        reset_pulse(3);

        // Clear phase with random traffic that must be ignored; ready checked every cycle.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rand_inputs(DEPTH - 1);
            cycle();
        end
        check_bit("ready_after_clear", ready, 1'b1);

        set_a(1'b1, 1'b0, '0, AW'(0), '0);
        set_b(1'b1, 1'b0, '0, AW'(64), '0);
        cycle();
        set_a(1'b1, 1'b0, '0, AW'(127), '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
        cycle();
        idle();
        idle();
        check("clear_rd64", b_rdata, 32'h0);
        check("clear_rd127", a_rdata, 32'h0);

        // Byte-enable merge, read back through port B.
        set_a(1'b1, 1'b1, 4'hF, AW'(5), 32'hDEADBEEF);
        cycle();
        set_a(1'b1, 1'b1, 4'h1, AW'(5), 32'h000000AA);
        cycle();
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b1, 1'b0, '0, AW'(5), '0);
        cycle();
        idle();
        idle();
        check("be_merge", b_rdata, 32'hDEADBEAA);

        // Write/write collisions on the same word.
        set_a(1'b1, 1'b1, 4'hF, AW'('h10), 32'h11111111);
        set_b(1'b1, 1'b1, 4'h3, AW'('h10), 32'h22222222);
        cycle();
        check_bit("coll_pulse", collision, 1'b1);
        set_a(1'b1, 1'b0, '0, AW'('h10), '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
        cycle();
        check_bit("coll_drop", collision, 1'b0);
        idle();
        idle();
        check("coll_a_full", a_rdata, 32'h11111111);
        set_a(1'b1, 1'b1, 4'hC, AW'('h10), 32'h11111111);
        set_b(1'b1, 1'b1, 4'h3, AW'('h10), 32'h22222222);
        cycle();
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b1, 1'b0, '0, AW'('h10), '0);
        cycle();
        idle();
        idle();
        check("coll_a_upper", b_rdata, 32'h11112222);

        // Read-first on a same-cycle read/write.
        set_a(1'b1, 1'b0, '0, AW'('h20), '0);
        set_b(1'b1, 1'b1, 4'hF, AW'('h20), 32'hCAFEF00D);
        cycle();
        idle();
        idle();
        check("read_first_old", a_rdata, 32'h0);
        set_a(1'b1, 1'b0, '0, AW'('h20), '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
        cycle();
        idle();
        idle();
        check("read_first_new", a_rdata, 32'hCAFEF00D);

        // Dense random traffic on a few addresses to provoke overlaps.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(7);
            cycle();
        end

        // Reset in the middle of a clear restarts the full clear.
        reset_pulse(2);
        for (int i = 0; i < 50; i++) begin
            rand_inputs(DEPTH - 1);
            cycle();
        end
        reset_pulse(3);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rand_inputs(DEPTH - 1);
            cycle();
        end
        check_bit("ready_after_reclear", ready, 1'b1);
        for (int i = 0; i < 200; i++) begin
            rand_inputs(15);
            cycle();
        end

`ifdef SRAM2RW_PARITY_EN
        set_a(1'b1, 1'b1, 4'hF, AW'('h30), 32'h0F0F0F0F);
        set_b(1'b1, 1'b1, 4'hF, AW'('h31), 32'h0F0F0F0F);
        cycle();
        idle();
        dut.mem['h30][9] = ~dut.mem['h30][9];
        mem_m['h30][9]   = ~mem_m['h30][9];
        bad_m['h30]      = 1'b1;
        set_a(1'b1, 1'b0, '0, AW'('h30), '0);
        set_b(1'b1, 1'b0, '0, AW'('h31), '0);
        cycle();
        idle();
        idle();
        check("perr_data", a_rdata, 32'h0F0F0D0F);
`endif

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
